// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: state encodings, command bytes, timing defaults and
// field widths used by the host transmit path (and the receive path).
package ps2_host_tx_pkg;

  // XFER is reserved for the receive path; the transmitter moves straight from REQ to ACK.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_XFER      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;     // 100 us at 50 MHz
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;  // 20 ms at 50 MHz
  localparam int unsigned DEF_SYNC_STAGES    = 2;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 20;  // shared inhibit / timeout counter
  localparam int unsigned EDGE_W = 4;   // device clock falling-edge counter

  // Odd parity bit: makes the total number of ones in data+parity odd.
  function automatic logic odd_parity(input logic [BYTE_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// Multi-stage synchronizer for one raw PS/2 pin plus a falling-edge detector.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   pin          : raw asynchronous pin level
//   level        : synchronized level (idles high after reset)
//   fall_c       : combinational pulse, synced level was 1 last cycle and is 0 now
module ps2_host_tx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_prev;

  // Reset to 1 so a released (pulled-up) line never looks like a fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '1;
      level_prev <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pin};
      level_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign fall_c = level_prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts out one byte LSB first with odd parity and stop bit on device clock
// falls, then samples the device ACK. Every output is registered.
// Ports:
//   clock, reset             : system clock, synchronous active-high reset
//   tx_start, tx_data        : request pulse and byte, accepted only when tx_ready
//   tx_ready, busy           : idle indication and its complement
//   tx_done, tx_error        : one-cycle end-of-transfer pulse, error qualifier
//   ps2_clk_in, ps2_data_in  : raw open-drain pin levels
//   ps2_clk_oe, ps2_data_oe  : 1 = pull the corresponding line low
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              busy,
  output logic              tx_done,
  output logic              tx_error,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe
);

  localparam logic [CNT_W-1:0]  INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  INHIBIT_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [EDGE_W-1:0] DATA_EDGES   = EDGE_W'(8);

  logic clk_s, clk_fall_c;
  logic data_s, data_fall_unused_c;

  ps2_host_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clock  (clock),
    .reset  (reset),
    .pin    (ps2_clk_in),
    .level  (clk_s),
    .fall_c (clk_fall_c)
  );

  // Data line only needs its level; its edge output is not used by this path.
  ps2_host_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clock  (clock),
    .reset  (reset),
    .pin    (ps2_data_in),
    .level  (data_s),
    .fall_c (data_fall_unused_c)
  );

  ps2_state_e         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [EDGE_W-1:0]  edge_cnt, edge_cnt_d;
  logic [BYTE_W-1:0]  shift, shift_d;
  logic               parity, parity_d;
  logic               ack_fail, ack_fail_d;
  logic               clk_oe_d, data_oe_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    edge_cnt_d = edge_cnt;
    shift_d    = shift;
    parity_d   = parity;
    ack_fail_d = ack_fail;
    data_oe_d  = ps2_data_oe;

    unique case (state)
      S_IDLE: begin
        if (tx_start) begin
          state_d    = S_INHIBIT;
          cnt_d      = '0;
          edge_cnt_d = '0;
          shift_d    = tx_data;
          parity_d   = odd_parity(tx_data);
          ack_fail_d = 1'b0;
          // A one-cycle inhibit is also its own last cycle.
          data_oe_d  = (INHIBIT_CYCLES == 1);
        end
      end

      S_INHIBIT: begin
        cnt_d = cnt + CNT_W'(1);
        // Start bit goes low in the last inhibit cycle while the clock is still held.
        if (cnt == INHIBIT_PRE) begin
          data_oe_d = 1'b1;
        end
        if (cnt == INHIBIT_LAST) begin
          state_d    = S_REQ;
          cnt_d      = '0;
          edge_cnt_d = '0;
          data_oe_d  = 1'b1;
        end
      end

      S_REQ, S_ACK, S_WAIT_IDLE: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == TIMEOUT_LAST) begin
          state_d    = S_DONE;
          ack_fail_d = 1'b1;
          data_oe_d  = 1'b0;
        end else if (state == S_REQ) begin
          // Drive the next bit right after each fall so it settles before the rise.
          if (clk_fall_c) begin
            edge_cnt_d = edge_cnt + EDGE_W'(1);
            if (edge_cnt < DATA_EDGES) begin
              data_oe_d = ~shift[0];
              shift_d   = {1'b0, shift[BYTE_W-1:1]};
            end else if (edge_cnt == DATA_EDGES) begin
              data_oe_d = ~parity;
            end else begin
              data_oe_d = 1'b0;
              state_d   = S_ACK;
            end
          end
        end else if (state == S_ACK) begin
          if (clk_fall_c) begin
            ack_fail_d = data_s;
            state_d    = S_WAIT_IDLE;
          end
        end else if (clk_s && data_s) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        edge_cnt_d = '0;
      end

      default: begin
        state_d   = S_IDLE;
        data_oe_d = 1'b0;
      end
    endcase

    clk_oe_d = (state_d == S_INHIBIT);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      edge_cnt    <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      ack_fail    <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      edge_cnt    <= edge_cnt_d;
      shift       <= shift_d;
      parity      <= parity_d;
      ack_fail    <= ack_fail_d;
      tx_ready    <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      tx_done     <= (state_d == S_DONE);
      tx_error    <= (state_d == S_DONE) && ack_fail_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain lines with pull-ups and a PS/2 device model
// that clocks the frame in, decodes it, and acks (or not) on request.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INHIBIT = 50;
  localparam int unsigned TIMEOUT = 20000;
  localparam int          HALF    = 20;  // device clock half period in system cycles

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b0;   // 1 = device pulls clock low
  logic       dev_data = 1'b0;  // 1 = device pulls data low
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk);
  assign data_line = ~(ps2_data_oe | dev_data);

  always #10 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT),
    .SYNC_STAGES    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    bit          poke;       // pulse tx_start while busy and in the DONE cycle
    logic [10:0] exp_frame;  // {stop, parity, d7..d0, start}
    bit          exp_err;
  } vec_t;

  vec_t vecs [5];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Device side: wait for request, clock out 11 bits (or stop at fall stop_at), then ack.
  task automatic dev_xfer(input bit ack, input int stop_at, output logic [10:0] frame,
                          output int inh_len);
    int waited;
    frame   = '0;
    inh_len = 0;
    waited  = 0;
    while (!(clk_line && !data_line) && waited < 2000) begin
      if (ps2_clk_oe) inh_len++;
      @(negedge clock);
      waited++;
    end
    check("request_seen", 32'(waited < 2000), 32'(1));
    if (waited >= 2000) return;
    repeat (HALF) @(negedge clock);
    frame[0] = data_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b1;
      if (i == stop_at) begin
        repeat (HALF / 2) @(negedge clock);
        return;
      end
      repeat (HALF) @(negedge clock);
      frame[i] = data_line;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock);
    end
    if (ack) dev_data = 1'b1;
    repeat (HALF / 2) @(negedge clock);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clock);
    dev_clk  = 1'b0;
    dev_data = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [10:0] frame;
    int          inh;
    int          waited;
    int          stray;
    bit          seen;
    logic        err;
    @(negedge clock);
    tx_data  = v.data;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    fork
      dev_xfer(v.ack, 0, frame, inh);
      if (v.poke) begin
        repeat (20) @(negedge clock);
        tx_data  = 8'h12;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
      end
    join
    seen   = 1'b0;
    err    = 1'b0;
    waited = 0;
    while (!seen && waited < 200) begin
      if (tx_done) begin
        seen = 1'b1;
        err  = tx_error;
        if (v.poke) begin
          tx_data  = 8'h34;
          tx_start = 1'b1;
        end
      end
      @(negedge clock);
      waited++;
    end
    tx_start = 1'b0;
    check({tag, "_inhibit_len"}, 32'(inh), 32'(INHIBIT));
    check({tag, "_frame"}, 32'(frame), 32'(v.exp_frame));
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    check({tag, "_error"}, 32'(err), 32'(v.exp_err));
    check({tag, "_ready_after"}, 32'(tx_ready), 32'(1));
    check({tag, "_done_one_cycle"}, 32'(tx_done), 32'(0));
    stray = 0;
    repeat (60) begin
      @(negedge clock);
      if (ps2_clk_oe || !tx_ready || tx_done) stray++;
    end
    check({tag, "_no_extra_xfer"}, 32'(stray), 32'(0));
  endtask

  initial begin
    #1_400_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] frame;
    int          inh;
    int          cnt;
    int          waited;
    vec_t        v_ff;

    vecs[0] = '{data: PS2_CMD_SET_LEDS, ack: 1'b1, poke: 1'b0, exp_frame: 11'h7DA, exp_err: 1'b0};
    vecs[1] = '{data: 8'h00,            ack: 1'b1, poke: 1'b0, exp_frame: 11'h600, exp_err: 1'b0};
    vecs[2] = '{data: 8'h01,            ack: 1'b1, poke: 1'b0, exp_frame: 11'h402, exp_err: 1'b0};
    vecs[3] = '{data: 8'h80,            ack: 1'b0, poke: 1'b0, exp_frame: 11'h500, exp_err: 1'b1};
    vecs[4] = '{data: PS2_RSP_ACK,      ack: 1'b1, poke: 1'b1, exp_frame: 11'h7F4, exp_err: 1'b0};
    v_ff    = '{data: PS2_CMD_RESET,    ack: 1'b1, poke: 1'b0, exp_frame: 11'h7FE, exp_err: 1'b0};

    // Reset state
    repeat (5) @(negedge clock);
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tx_done", 32'(tx_done), 32'(0));
    check("rst_tx_error", 32'(tx_error), 32'(0));
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'(0));
    check("rst_data_oe", 32'(ps2_data_oe), 32'(0));
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Device never clocks: timeout exactly TIMEOUT cycles after REQ entry.
    @(negedge clock);
    tx_data  = PS2_CMD_SET_LEDS;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    waited = 0;
    while (!(clk_line && !data_line) && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    check("to_request_seen", 32'(waited < 2000), 32'(1));
    cnt = 0;
    while (!tx_done && cnt < int'(TIMEOUT) + 100) begin
      @(negedge clock);
      cnt++;
    end
    check("to_latency", 32'(cnt), 32'(TIMEOUT));
    check("to_error", 32'(tx_error), 32'(1));
    check("to_clk_oe", 32'(ps2_clk_oe), 32'(0));
    check("to_data_oe", 32'(ps2_data_oe), 32'(0));
    @(negedge clock);
    check("to_ready_after", 32'(tx_ready), 32'(1));
    repeat (5) @(negedge clock);

    // Reset at device edge 5 of a transfer.
    @(negedge clock);
    tx_data  = PS2_CMD_SET_LEDS;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    dev_xfer(1'b1, 5, frame, inh);
    check("abort_pre_data_oe", 32'(ps2_data_oe), 32'(1));
    check("abort_pre_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    @(negedge clock);
    check("abort_clk_oe", 32'(ps2_clk_oe), 32'(0));
    check("abort_data_oe", 32'(ps2_data_oe), 32'(0));
    check("abort_tx_ready", 32'(tx_ready), 32'(1));
    check("abort_tx_done", 32'(tx_done), 32'(0));
    reset   = 1'b0;
    dev_clk = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(negedge clock);
      if (tx_done || tx_error || busy) cnt++;
    end
    check("abort_quiet", 32'(cnt), 32'(0));
    run_vec(v_ff, "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
